// File: rtl/led_step_ctrl.sv
// Purpose: debounced three-button speed/run control that emits one-cycle step pulses for an LED shifter.
// Latency: a held button takes 2 (sync) + DEB_CYCLES (debounce) + 1 (event) + 1 (apply) edges to act; step is registered.
// Backpressure: none; step is a free-running pulse and the downstream shifter must accept every pulse.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   btn_up     raw "faster" button (async, active-high)
//   btn_dn     raw "slower" button (async, active-high)
//   btn_pause  raw run/pause toggle button (async, active-high)
//   step       one-cycle pulse, one per step period P = BASE_DIV * (8 - speed)
//   speed      current speed level, 0 slowest .. 7 fastest
//   running    1 while running, 0 while paused
module led_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int BASE_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_pause,
    output logic       step,
    output logic [2:0] speed,
    output logic       running
);

    // Prescaler must hold values up to the slowest period minus one.
    localparam int CW = $clog2(8 * BASE_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    // Button index: 0 = up, 1 = down, 2 = pause.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    ev;
    logic [DW-1:0] dcnt [3];

    assign raw = {btn_pause, btn_dn, btn_up};

    // Synchronizer, debouncer and rising-edge event generator per button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            ev    <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // Event lands one cycle after the debounced level rises; releases are ignored.
            ev    <= deb & ~deb_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    // The flip happens on the DEB_CYCLES-th consecutive differing sample.
                    if (dcnt[i] == DEB_LAST) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    // Any agreeing sample restarts the stability count.
                    dcnt[i] <= '0;
                end
            end
        end
    end

    logic up_ev;
    logic dn_ev;
    logic pause_ev;

    assign up_ev    = ev[0];
    assign dn_ev    = ev[1];
    assign pause_ev = ev[2];

    logic          spd_chg;
    logic [2:0]    spd_next;
    logic [CW-1:0] last;
    logic [CW-1:0] cnt;
    state_t        state;

    // Simultaneous up/down cancel; saturated requests are no-ops.
    always_comb begin
        spd_chg  = 1'b0;
        spd_next = speed;
        if (up_ev && !dn_ev && (speed != 3'd7)) begin
            spd_chg  = 1'b1;
            spd_next = speed + 3'd1;
        end else if (dn_ev && !up_ev && (speed != 3'd0)) begin
            spd_chg  = 1'b1;
            spd_next = speed - 3'd1;
        end
    end

    // Terminal count of the current step period.
    always_comb begin
        last = CW'(BASE_DIV * (8 - int'(speed)) - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            running <= 1'b1;
            speed   <= 3'd3;
            cnt     <= '0;
            step    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pause_ev) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pause_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            endcase

            if (spd_chg) begin
                // A speed change restarts the period and swallows any step due on this edge.
                speed <= spd_next;
                cnt   <= '0;
                step  <= 1'b0;
            end else if (state == RUN) begin
                if (cnt == last) begin
                    cnt  <= '0;
                    // Only a one-cycle period could request back-to-back steps; every other one is dropped.
                    step <= ~step;
                end else begin
                    cnt  <= cnt + 1'b1;
                    step <= 1'b0;
                end
            end else begin
                step <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Purpose: self-checking bench for led_step_ctrl against a cycle-level behavioural model.
// Latency: compares step/speed/running 1 time unit after every rising edge.
// Backpressure: not applicable; stimulus is directed scenarios followed by random button activity.
module tb_led_step_ctrl;

    localparam int DEB  = 4;
    localparam int BDIV = 2;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_pause;
    logic       step;
    logic [2:0] speed;
    logic       running;

    led_step_ctrl #(
        .DEB_CYCLES (DEB),
        .BASE_DIV   (BDIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .btn_pause (btn_pause),
        .step      (step),
        .speed     (speed),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed;
    int total;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model state.
    int m_h1 [3];      // raw value seen at the previous edge
    int m_h2 [3];      // raw value seen two edges ago (what the debouncer samples)
    int m_lvl [3];     // debounced level
    int m_run [3];     // consecutive samples disagreeing with the level
    int m_q1 [3];      // rise detected this edge
    int m_q2 [3];      // event waiting to be applied on the next edge
    int m_speed;
    int m_cnt;
    int m_running;
    int m_step;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_q1[b] = 0; m_q2[b] = 0;
        end
        m_speed = 3; m_cnt = 0; m_running = 1; m_step = 0;
    endtask

    task automatic model_edge(input logic [2:0] rawv);
        int use_ev [3];
        int samp;
        int was_running;
        int new_speed;
        int period;
        for (int b = 0; b < 3; b++) begin
            use_ev[b] = m_q2[b];
            m_q2[b]   = m_q1[b];
            m_q1[b]   = 0;
            samp      = m_h2[b];
            m_h2[b]   = m_h1[b];
            m_h1[b]   = int'(rawv[b]);
            if (samp != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = samp;
                    m_run[b] = 0;
                    if (samp == 1) m_q1[b] = 1;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        was_running = m_running;
        if (use_ev[2] == 1) m_running = 1 - m_running;
        new_speed = m_speed;
        if (use_ev[0] == 1 && use_ev[1] == 0) new_speed = m_speed + 1;
        if (use_ev[1] == 1 && use_ev[0] == 0) new_speed = m_speed - 1;
        if (new_speed > 7) new_speed = 7;
        if (new_speed < 0) new_speed = 0;
        if (new_speed != m_speed) begin
            m_speed = new_speed;
            m_cnt   = 0;
            m_step  = 0;
        end else if (was_running == 1) begin
            period = BDIV * (8 - m_speed);
            if (m_cnt == period - 1) begin
                m_cnt  = 0;
                m_step = (m_step == 1) ? 0 : 1;
            end else begin
                m_cnt  = m_cnt + 1;
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge({btn_pause, btn_dn, btn_up});
        chk("step", int'(step), m_step);
        chk("speed", int'(speed), m_speed);
        chk("running", int'(running), m_running);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b, input int hold, input int gap);
        if (b == 0) btn_up = 1'b1;
        if (b == 1) btn_dn = 1'b1;
        if (b == 2) btn_pause = 1'b1;
        ticks(hold);
        btn_up = 1'b0; btn_dn = 1'b0; btn_pause = 1'b0;
        ticks(gap);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_step"}, int'(step), 0);
        chk({tag, "_speed"}, int'(speed), 3);
        chk({tag, "_running"}, int'(running), 1);
    endtask

    int seg_len;
    int seg_cnt;

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b0;
        btn_up = 1'b0; btn_dn = 1'b0; btn_pause = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b1;

        // Idle run at default speed.
        ticks(35);

        // Short glitch ignored, then a held press speeds up by one.
        btn_up = 1'b1; ticks(3); btn_up = 1'b0; ticks(10);
        chk("glitch_speed", int'(speed), 3);
        press(0, 20, 30);
        chk("held_up_speed", int'(speed), 4);

        // Saturate high, then low.
        for (int i = 0; i < 5; i++) press(0, 8, 8);
        chk("sat_hi", int'(speed), 7);
        ticks(10);
        for (int i = 0; i < 10; i++) press(1, 8, 8);
        chk("sat_lo", int'(speed), 0);
        ticks(40);

        // Pause, hold, resume.
        press(2, 8, 25);
        chk("paused", int'(running), 0);
        press(2, 8, 30);
        chk("resumed", int'(running), 1);

        // Simultaneous up and down cancel.
        btn_up = 1'b1; btn_dn = 1'b1; ticks(15);
        btn_up = 1'b0; btn_dn = 1'b0; ticks(15);
        chk("cancel_speed", int'(speed), 0);

        // Asynchronous reset mid-period: outputs must change before any edge.
        press(0, 8, 13);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        check_reset_vals("held");
        model_reset();
        reset = 1'b1;
        ticks(25);

        // Button held across reset release yields exactly one event.
        @(posedge clk);
        #1;
        reset = 1'b0;
        btn_pause = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        ticks(30);
        chk("held_at_reset", int'(running), 0);
        btn_pause = 1'b0;
        ticks(10);

        // Random button activity.
        seg_cnt = 0;
        while (seg_cnt < 300) begin
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_dn    = ($urandom_range(0, 3) == 0);
            btn_pause = ($urandom_range(0, 7) == 0);
            seg_len   = $urandom_range(1, 12);
            ticks(seg_len);
            seg_cnt++;
        end
        btn_up = 1'b0; btn_dn = 1'b0; btn_pause = 1'b0;
        ticks(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
